timer_counter: RTL
==================

Name: timer_counter

Overview:
- Counting stage directly downstream of the timer register block; consumes its control outputs and returns count, compare and halt status.
- Holds the 64-bit free-running counter and the clock-divider prescaler.
- Generates the compare-match pulse that sets the interrupt status bit, and the debug-halt acknowledge.
- Serves TDR0/TDR1 writes by reloading the counter from the register block's TDR copy.

Parameters:
- CNT_W, 64, counter width (TDR/tcmp/cnt_val width).
- PSC_W, 8, prescaler width; must hold 2^DIV_MAX-1.
- DIV_MAX, 8, largest legal div_val.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- timer_en  in  1  counter enable (TCR[0])
- div_en  in  1  divider enable (TCR[1])
- div_val  in  4  divide exponent, tick period 2^div_val (0..8)
- halt_req  in  1  debug halt request (THCSR[0])
- dbg_mode  in  1  CPU in debug mode; halt honoured only when high
- TDR  in  CNT_W  register block copy of {TDR1,TDR0}
- tdr0_wr_en  in  1  APB write strobe to TDR0 (same cycle as register update)
- tdr1_wr_en  in  1  APB write strobe to TDR1
- tcmp  in  CNT_W  compare value {TCMP1,TCMP0}
- cnt_val  out  CNT_W  current counter value
- cmp_match  out  1  registered compare-equal flag
- halt_ack  out  1  registered halt acknowledge

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n); every flop clears only on a clk edge with rst_n=0.
- Reset values: cnt_val=0, cmp_match=0, halt_ack=0, prescaler=0, load-pending flags=0.
- halt_ack <= halt_req & dbg_mode, registered; asserts and deasserts 1 cycle after its inputs.
- active = timer_en & ~halt_ack.
- Prescaler, div_en=0: tick every cycle while active; prescaler held at 0.
- Prescaler, div_en=1: while active, prescaler counts 0..2^div_val-1 and wraps to 0. Tick is asserted in the cycle prescaler == 2^div_val-1.
- div_val=0 with div_en=1: tick every cycle.
- div_val>DIV_MAX: treated as DIV_MAX. The register block already rejects this; clamping is a safety measure.
- Prescaler clears to 0 whenever timer_en=0. It holds its value while halt_ack=1.
- Counter: on tick, cnt <= cnt+1, modulo 2^CNT_W. All-ones wraps to 0 with no flag.
- timer_en=0: counter holds its value; it is not cleared.
- TDR load: tdr0_wr_en/tdr1_wr_en is registered into ld0/ld1. The register block updates TDR on that same edge, so in the following cycle cnt[31:0] <= TDR[31:0] (ld0) and/or cnt[63:32] <= TDR[63:32] (ld1). Load latency is 1 cycle after the strobe.
- Load in progress: the readback shows the pre-load value for exactly one cycle.
- Load vs increment: a load takes priority over a tick in the same cycle. With only ld0, the upper half still increments, including any carry out of the pre-load lower half. Loads also occur while halted or disabled.
- Prescaler on load: unaffected.
- cmp_match <= (cnt == tcmp), registered: high the cycle after equality. It stays high for as long as equality persists (e.g. counter halted or disabled at tcmp).
- Reset mid-count, mid-load or mid-halt: all state returns to its reset values; pending loads are discarded.

Decomposition:
- Shared package timer_pkg: CNT_W, DIV_MAX, TDR0/TDR1 half-select constants.
- Sub-module timer_prescaler: inputs clk, rst_n, active, timer_en, div_en, div_val; output tick.
- Counter, load and compare logic stay in timer_counter.

Test Plan:
- Reset, then timer_en=1, div_en=0 for 10 cycles -> cnt_val = 0..10 incrementing each cycle; cmp_match=0, halt_ack=0.
- div_en=1, div_val=2, timer_en=1 -> cnt_val increments once every 4 cycles. div_val=8 -> once every 256 cycles. div_val=0 -> every cycle.
- Pulse tdr0_wr_en with TDR=0x0000_0001_FFFF_FFFE while counting at div 1 -> cycle+1 cnt_val[31:0]=0xFFFF_FFFE. Then count proceeds to 0x...FFFF_FFFF, then carries into the upper half.
- Load cnt=0xFFFF_FFFF_FFFF_FFFF with tcmp=0 -> next tick cnt_val=0. cmp_match=1 one cycle later and stays high while timer_en is dropped.
- halt_req=1, dbg_mode=1 mid-count at div_val=3 -> halt_ack=1 after 1 cycle; cnt and prescaler frozen. halt_req=0 -> resumes from the frozen prescaler phase. halt_req=1 with dbg_mode=0 -> no ack.
- Assert rst_n=0 during a pending ld1 with halt_ack=1 -> all outputs 0 on the next edge; no load applied after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer counting stage: widths, divider limit and
// the bit positions of the TDR0/TDR1 halves within the 64-bit counter.
package timer_pkg;

  localparam int CNT_W   = 64;
  localparam int PSC_W   = 8;
  localparam int DIV_MAX = 8;

  localparam int HALF_W   = CNT_W / 2;
  localparam int TDR0_LSB = 0;
  localparam int TDR1_LSB = HALF_W;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Clock-divider prescaler: produces a one-cycle count tick every 2^div_val
// active cycles, or every active cycle when the divider is disabled.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int P_PSC_W   = PSC_W,
  parameter int P_DIV_MAX = DIV_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       active,
  input  logic       timer_en,
  input  logic       div_en,
  input  logic [3:0] div_val,
  output logic       tick
);

  logic [3:0]         w_div_eff;
  logic [P_PSC_W-1:0] w_limit;
  logic               w_at_limit;
  logic [P_PSC_W-1:0] r_psc;

  // Out-of-range exponents fall back to the largest legal divider.
  assign w_div_eff  = (div_val > 4'(P_DIV_MAX)) ? 4'(P_DIV_MAX) : div_val;
  assign w_limit    = ~({P_PSC_W{1'b1}} << w_div_eff);
  // >= also recovers cleanly if div_val shrinks while the prescaler is mid-period.
  assign w_at_limit = (r_psc >= w_limit);

  assign tick = active & (~div_en | w_at_limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psc <= '0;
    end else if (!timer_en || !div_en) begin
      r_psc <= '0;
    end else if (active) begin
      r_psc <= w_at_limit ? '0 : r_psc + 1'b1;
    end
  end

endmodule : timer_prescaler

// File: rtl/timer_counter.sv
// 64-bit free-running counter with prescaled tick, one-cycle-late TDR half
// reloads, registered compare-match and debug-halt acknowledge.
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W   = timer_pkg::CNT_W,
  parameter int PSC_W   = timer_pkg::PSC_W,
  parameter int DIV_MAX = timer_pkg::DIV_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic [3:0]       div_val,
  input  logic             halt_req,
  input  logic             dbg_mode,
  input  logic [CNT_W-1:0] TDR,
  input  logic             tdr0_wr_en,
  input  logic             tdr1_wr_en,
  input  logic [CNT_W-1:0] tcmp,
  output logic [CNT_W-1:0] cnt_val,
  output logic             cmp_match,
  output logic             halt_ack
);

  logic             r_halt_ack;
  logic             r_ld0;
  logic             r_ld1;
  logic             r_cmp_match;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_active;
  logic             w_tick;

  assign w_active = timer_en & ~r_halt_ack;

  timer_prescaler #(
    .P_PSC_W   (PSC_W),
    .P_DIV_MAX (DIV_MAX)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .active   (w_active),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .tick     (w_tick)
  );

  // Increment first so a lone ld0 still lets the pre-load lower-half carry
  // reach the upper half; loaded halves then override the sum.
  always_comb begin
    w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, w_tick};
    if (r_ld0) w_cnt_next[TDR0_LSB +: HALF_W] = TDR[TDR0_LSB +: HALF_W];
    if (r_ld1) w_cnt_next[TDR1_LSB +: HALF_W] = TDR[TDR1_LSB +: HALF_W];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_halt_ack  <= 1'b0;
      r_ld0       <= 1'b0;
      r_ld1       <= 1'b0;
      r_cmp_match <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_halt_ack  <= halt_req & dbg_mode;
      r_ld0       <= tdr0_wr_en;
      r_ld1       <= tdr1_wr_en;
      r_cmp_match <= (r_cnt == tcmp);
      r_cnt       <= w_cnt_next;
    end
  end

  assign cnt_val   = r_cnt;
  assign cmp_match = r_cmp_match;
  assign halt_ack  = r_halt_ack;

endmodule : timer_counter
